// File: rtl/bfp_block_scheduler.sv
// Ping-pong block framer for the BFP peak/leading-zero calculator: buffers
// BLOCK_LEN-sample blocks, captures each block's shift and replays it normalised.
module bfp_block_scheduler #(
  parameter int WIDTH     = 16,
  parameter int BLOCK_LEN = 64,
  parameter int SHW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             calc_valid,
  output logic             calc_last,
  output logic [WIDTH-1:0] calc_mag,
  input  logic [SHW-1:0]   calc_shift,
  input  logic             calc_shift_valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [SHW-1:0]   m_exp,
  output logic             m_last,
  output logic             err
);

  localparam int               CNT_W    = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  logic [1:0][1:0]     state;
  logic [1:0][SHW-1:0] exp_r;
  logic [WIDTH-1:0]    mem [2][BLOCK_LEN];
  logic                wr_bank;
  logic                rd_bank;
  logic                calc_bank;
  logic [CNT_W-1:0]    wr_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic                err_r;
  logic                wr_hs;
  logic                wr_at_last;
  logic                rd_hs;
  logic                rd_at_last;

  // A shift of WIDTH means the block peak was zero, so every sample is zero.
  function automatic logic [WIDTH-1:0] normalise(input logic [WIDTH-1:0] d,
                                                 input logic [SHW-1:0]   sh);
    if (int'(sh) >= WIDTH) return '0;
    return d << sh;
  endfunction

  assign s_ready    = (state[wr_bank] == ST_EMPTY) || (state[wr_bank] == ST_FILL);
  assign wr_hs      = s_valid & s_ready;
  assign wr_at_last = (wr_cnt == LAST_IDX);

  assign calc_valid = wr_hs;
  assign calc_last  = wr_hs & wr_at_last;
  assign calc_mag   = s_data;

  assign m_valid    = (state[rd_bank] == ST_FULL);
  assign rd_hs      = m_valid & m_ready;
  assign rd_at_last = (rd_cnt == LAST_IDX);
  assign m_last     = m_valid & rd_at_last;
  assign m_exp      = exp_r[rd_bank];
  assign m_data     = normalise(mem[rd_bank][rd_cnt], exp_r[rd_bank]);
  assign err        = err_r;

  always_ff @(posedge clk) begin
    if (wr_hs) mem[wr_bank][wr_cnt] <= s_data;
  end

  // Write, capture and read each touch a different bank (FILL/CALC/FULL are
  // disjoint), so all three may update state in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= '0;
      exp_r     <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      calc_bank <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      err_r     <= 1'b0;
    end else begin
      if (wr_hs) begin
        if (wr_at_last) begin
          state[wr_bank] <= ST_CALC;
          calc_bank      <= wr_bank;
          wr_bank        <= ~wr_bank;
          wr_cnt         <= '0;
        end else begin
          state[wr_bank] <= ST_FILL;
          wr_cnt         <= wr_cnt + CNT_W'(1);
        end
      end
      if (calc_shift_valid) begin
        if (state[calc_bank] == ST_CALC) begin
          exp_r[calc_bank] <= calc_shift;
          state[calc_bank] <= ST_FULL;
        end else begin
          err_r <= 1'b1;
        end
      end
      if (rd_hs) begin
        if (rd_at_last) begin
          state[rd_bank] <= ST_EMPTY;
          rd_bank        <= ~rd_bank;
          rd_cnt         <= '0;
        end else begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
